// File: rtl/sprite_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sprite_rom_arbiter_if
// Description : Bundle of the two pixel-fetch requester channels (A and B)
//               and the shared sprite ROM port used by sprite_rom_arbiter.
//               The slave modport is the arbiter side; the master modport is
//               the draw-unit / ROM side.
// Revision    : 1.0 - initial release
// ============================================================================
interface sprite_rom_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 12
);

  // Requester A channel
  logic              req_a;
  logic [ADDR_W-1:0] addr_a;
  logic              gnt_a;
  logic [DATA_W-1:0] rgb_a;
  logic              valid_a;

  // Requester B channel
  logic              req_b;
  logic [ADDR_W-1:0] addr_b;
  logic              gnt_b;
  logic [DATA_W-1:0] rgb_b;
  logic              valid_b;

  // Shared synchronous-read ROM port
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_rgb;

  // Arbiter side
  modport slave (
    input  req_a, addr_a, req_b, addr_b, rom_rgb,
    output gnt_a, rgb_a, valid_a, gnt_b, rgb_b, valid_b, rom_addr
  );

  // Requesters plus ROM side
  modport master (
    output req_a, addr_a, req_b, addr_b, rom_rgb,
    input  gnt_a, rgb_a, valid_a, gnt_b, rgb_b, valid_b, rom_addr
  );

endinterface
`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sprite_rom_arbiter
// Description : Round-robin arbiter sharing one 1-cycle synchronous-read
//               sprite ROM between two pixel-fetch requesters. One access per
//               clock, fixed 3-cycle grant-to-valid latency, results routed
//               back to the issuing requester via an owner-tag pipeline.
// Option      : SPRITE_ARB_BOUND_CHECK_EN - when defined, granted addresses
//               >= ROM_DEPTH are not forwarded to the ROM and return black.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_rom_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 12,
  parameter int ROM_DEPTH = 12870
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sprite_rom_arbiter_if.slave  bus
);

  // A depth that cannot be addressed (or is empty) is a build error.
  generate
    if (ROM_DEPTH < 1 || ROM_DEPTH > (1 << ADDR_W)) begin : g_depth_check
      $error("sprite_rom_arbiter: ROM_DEPTH does not fit ADDR_W");
    end
  endgenerate

  // Priority pointer: 0 means A wins the next contention, 1 means B wins.
  logic              ptr_q;
  logic              ptr_d;

  // Grant decode for the current cycle.
  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              w_grant;
  logic [ADDR_W-1:0] w_win_addr;
  logic              w_oob;

  // Registered ROM address.
  logic [ADDR_W-1:0] rom_addr_q;
  logic [ADDR_W-1:0] rom_addr_d;

  // Owner tag pipeline. Stage 0 is live while the ROM sees the address,
  // stage 1 while the ROM data is on rom_rgb, stage 2 while the result is
  // presented to its owner.
  logic [2:0]        tag_vld_q;
  logic [2:0]        tag_id_q;

  // Returned pixels, held between results.
  logic [DATA_W-1:0] rgb_a_q;
  logic [DATA_W-1:0] rgb_b_q;
  logic [DATA_W-1:0] w_ret_rgb;

`ifdef SPRITE_ARB_BOUND_CHECK_EN
  // One extra bit keeps the comparison unsigned and exact for any depth.
  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(ROM_DEPTH);

  // Out-of-range flag travels alongside the owner tag up to the return stage.
  logic [1:0]        tag_oob_q;
`endif

  // Round-robin grant: a lone requester always wins, contention goes to the
  // side the pointer favours; the pointer flips to the loser after a grant.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (bus.req_a && bus.req_b) begin
      if (!ptr_q) begin
        w_gnt_a = 1'b1;
      end else begin
        w_gnt_b = 1'b1;
      end
    end else begin
      w_gnt_a = bus.req_a;
      w_gnt_b = bus.req_b;
    end

    w_grant    = w_gnt_a | w_gnt_b;
    w_win_addr = w_gnt_b ? bus.addr_b : bus.addr_a;

    ptr_d = ptr_q;
    if (w_gnt_a) begin
      ptr_d = 1'b1;
    end else if (w_gnt_b) begin
      ptr_d = 1'b0;
    end
  end

  // Address forwarding: only in-range winners reach the ROM; otherwise the
  // ROM address holds so the ROM input stays quiet.
  always_comb begin
`ifdef SPRITE_ARB_BOUND_CHECK_EN
    w_oob = w_grant && ({1'b0, w_win_addr} >= c_depth);
`else
    w_oob = 1'b0;
`endif
    rom_addr_d = rom_addr_q;
    if (w_grant && !w_oob) begin
      rom_addr_d = w_win_addr;
    end
  end

  // Data returned to the owner: ROM word, or transparent black for an
  // out-of-range fetch.
  always_comb begin
`ifdef SPRITE_ARB_BOUND_CHECK_EN
    w_ret_rgb = tag_oob_q[1] ? '0 : bus.rom_rgb;
`else
    w_ret_rgb = bus.rom_rgb;
`endif
  end

  // Pointer, ROM address, owner tags and per-requester result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= 1'b0;
      rom_addr_q <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      rgb_a_q    <= '0;
      rgb_b_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rom_addr_q <= rom_addr_d;
      tag_vld_q  <= {tag_vld_q[1:0], w_grant};
      tag_id_q   <= {tag_id_q[1:0], w_gnt_b};
      if (tag_vld_q[1]) begin
        if (tag_id_q[1]) begin
          rgb_b_q <= w_ret_rgb;
        end else begin
          rgb_a_q <= w_ret_rgb;
        end
      end
    end
  end

`ifdef SPRITE_ARB_BOUND_CHECK_EN
  // Out-of-range flags follow the owner tags through the first two stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_oob_q <= '0;
    end else begin
      tag_oob_q <= {tag_oob_q[0], w_oob};
    end
  end
`endif

  assign bus.gnt_a    = w_gnt_a;
  assign bus.gnt_b    = w_gnt_b;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rgb_a    = rgb_a_q;
  assign bus.rgb_b    = rgb_b_q;
  // The final tag stage is a flop, so the valid pulses are glitch-free and
  // mutually exclusive by construction (one id per stage).
  assign bus.valid_a  = tag_vld_q[2] & ~tag_id_q[2];
  assign bus.valid_b  = tag_vld_q[2] &  tag_id_q[2];

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_rom_arbiter
// Description : Self-checking bench for sprite_rom_arbiter. A queue-based
//               reference model predicts grants, ROM addresses and returned
//               pixels; directed scenarios are followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_rom_arbiter;

  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 12;
  localparam int ROM_DEPTH = 12870;
`ifdef SPRITE_ARB_BOUND_CHECK_EN
  localparam bit BOUND_CHECK = 1'b1;
`else
  localparam bit BOUND_CHECK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sprite_rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sprite_rom_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .ROM_DEPTH(ROM_DEPTH)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Contents of the sprite ROM model (defined for every 14-bit address).
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    int v;
    v = int'(a) * 1237 + 1443;
    return DATA_W'(v ^ (int'(a) >> 2));
  endfunction

  // Shared ROM with a one-cycle registered read.
  always @(posedge clk) bus.rom_rgb <= rom_word(bus.rom_addr);

  // Reference model state.
  typedef struct {
    int                due;
    bit                id;
    logic [DATA_W-1:0] data;
  } exp_t;
  exp_t              exp_q[$];
  int                cyc   = 0;
  int                tests = 0;
  int                fails = 0;
  bit                prio_b;
  logic [ADDR_W-1:0] e_rom;
  logic [DATA_W-1:0] e_rgb_a;
  logic [DATA_W-1:0] e_rgb_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    prio_b  = 1'b0;
    e_rom   = '0;
    e_rgb_a = '0;
    e_rgb_b = '0;
  endtask

  task automatic check_outputs(input logic e_va, input logic e_vb);
    chk("rom_addr", 32'(bus.rom_addr), 32'(e_rom));
    chk("valid_a",  32'(bus.valid_a),  32'(e_va));
    chk("valid_b",  32'(bus.valid_b),  32'(e_vb));
    chk("rgb_a",    32'(bus.rgb_a),    32'(e_rgb_a));
    chk("rgb_b",    32'(bus.rgb_b),    32'(e_rgb_b));
  endtask

  // One clock of traffic. Entered and left 1 time unit after a rising edge.
  task automatic step(input logic ra, input logic [ADDR_W-1:0] aa,
                      input logic rb, input logic [ADDR_W-1:0] ab,
                      output logic ga, output logic gb);
    logic [ADDR_W-1:0] win;
    bit                oob;
    exp_t              e;
    logic              e_va;
    logic              e_vb;
    bus.req_a  = ra;
    bus.addr_a = aa;
    bus.req_b  = rb;
    bus.addr_b = ab;
    #1;
    ga = ra && (!rb || !prio_b);
    gb = rb && !ga;
    chk("gnt_a", 32'(bus.gnt_a), 32'(ga));
    chk("gnt_b", 32'(bus.gnt_b), 32'(gb));
    if (ga || gb) begin
      win = ga ? aa : ab;
      oob = BOUND_CHECK && (int'(win) >= ROM_DEPTH);
      if (!oob) e_rom = win;
      e.due  = cyc + 3;
      e.id   = gb;
      e.data = oob ? '0 : rom_word(win);
      exp_q.push_back(e);
      prio_b = ga;
    end
    @(posedge clk);
    cyc++;
    #1;
    e_va = 1'b0;
    e_vb = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      if (e.id) begin
        e_vb    = 1'b1;
        e_rgb_b = e.data;
      end else begin
        e_va    = 1'b1;
        e_rgb_a = e.data;
      end
    end
    check_outputs(e_va, e_vb);
  endtask

  // Asynchronous reset held for three edges; checks take effect at once.
  task automatic do_reset();
    rst_n     = 1'b0;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    #1;
    model_reset();
    check_outputs(1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check_outputs(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic              ga;
    logic              gb;
    logic              cur_ra;
    logic              cur_rb;
    logic [ADDR_W-1:0] cur_aa;
    logic [ADDR_W-1:0] cur_ab;

    rst_n      = 1'b0;
    bus.req_a  = 1'b0;
    bus.req_b  = 1'b0;
    bus.addr_a = '0;
    bus.addr_b = '0;
    model_reset();
    #1;

    // Reset then idle.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, '0, ga, gb);

    // Single A request.
    step(1'b1, 14'd100, 1'b0, '0, ga, gb);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, '0, ga, gb);

    // Contention, both held for six cycles.
    for (int i = 0; i < 6; i++) step(1'b1, 14'd5, 1'b1, 14'd7, ga, gb);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, '0, ga, gb);

    // Streaming: A alone, addresses 0..63 back to back.
    for (int i = 0; i < 64; i++) step(1'b1, ADDR_W'(i), 1'b0, '0, ga, gb);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, '0, ga, gb);

    // Reset mid-flight: two grants in flight are discarded.
    step(1'b1, 14'd10, 1'b0, '0, ga, gb);
    step(1'b0, '0, 1'b1, 14'd20, ga, gb);
    do_reset();
    step(1'b1, 14'd30, 1'b1, 14'd40, ga, gb);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, '0, ga, gb);

    // First out-of-range address, and the last valid one.
    step(1'b0, '0, 1'b1, 14'd12870, ga, gb);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, '0, ga, gb);
    step(1'b1, 14'd12869, 1'b1, 14'd16383, ga, gb);
    step(1'b1, 14'd12869, 1'b1, 14'd16383, ga, gb);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, '0, ga, gb);

    // Random traffic; addresses held while a request waits for its grant.
    cur_ra = 1'b0;
    cur_rb = 1'b0;
    cur_aa = '0;
    cur_ab = '0;
    ga     = 1'b0;
    gb     = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!(cur_ra && !ga)) begin
        cur_ra = ($urandom_range(0, 3) != 0);
        cur_aa = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom_range(12860, 16383))
                                             : ADDR_W'($urandom_range(0, ROM_DEPTH - 1));
      end
      if (!(cur_rb && !gb)) begin
        cur_rb = ($urandom_range(0, 3) != 0);
        cur_ab = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom_range(12860, 16383))
                                             : ADDR_W'($urandom_range(0, ROM_DEPTH - 1));
      end
      step(cur_ra, cur_aa, cur_rb, cur_ab, ga, gb);
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, '0, ga, gb);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
